// File: rtl/maxpool_pkg.sv
// Shared definitions for the max-pool sequencer: FSM state encoding,
// per-channel pixel/output counts and the default pixel width.
package maxpool_pkg;

    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        DRAIN,
        NEXT,
        FIN
    } state_t;

    // Input pixels per channel.
    function automatic int unsigned pix_per_ch(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

    // Pooled outputs per channel for a 2x2/stride-2 window (odd edges truncated).
    function automatic int unsigned out_per_ch(input int unsigned w, input int unsigned h);
        return (w / 2) * (h / 2);
    endfunction

endpackage

// File: rtl/maxpool_addr_gen.sv
// Loadable address counter: load a base, force an arbitrary value, or step by one.
// Priority is load > force > increment. Wraps modulo 2^ADDR_W.
// Ports: clk, rst (async active-high), load/base, force_en/force_val, inc, addr.
module maxpool_addr_gen
    import maxpool_pkg::*;
#(
    parameter int unsigned ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic              force_en,
    input  logic [ADDR_W-1:0] force_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (load) begin
            addr <= base;
        end else if (force_en) begin
            addr <= force_val;
        end else if (inc) begin
            addr <= addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/maxpool_seq_ctrl.sv
// Channel-by-channel sequencer feeding a shared 2x2/stride-2 max-pool core.
// Streams each channel from source memory into the core, writes pooled
// results to destination memory, and fully drains the core before moving on.
// Ports: clk, rst (async active-high); command start/num_ch/src_base/dst_base;
// status busy/done/err; source read rd_en/rd_addr/rd_data; core interface
// pool_data_in/pool_valid_in/pool_data_out/pool_valid_out; destination write
// wr_en/wr_addr/wr_data.
// Optional: define MAXPOOL_SEQ_PERF_EN to add perf_cycles, a saturating count
// of busy cycles for the most recent command.
module maxpool_seq_ctrl
    import maxpool_pkg::*;
#(
    parameter int unsigned DATA_W        = DATA_W_DEF,
    parameter int unsigned ADDR_W        = 20,
    parameter int unsigned CH_W          = 10,
    parameter int unsigned IMG_W         = 299,
    parameter int unsigned IMG_H         = 299,
    parameter int unsigned DRAIN_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CH_W-1:0]   num_ch,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] pool_data_in,
    output logic              pool_valid_in,
    input  logic [DATA_W-1:0] pool_data_out,
    input  logic              pool_valid_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
`ifdef MAXPOOL_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    localparam int unsigned PIX_PER_CH = pix_per_ch(IMG_W, IMG_H);
    localparam int unsigned OUT_PER_CH = out_per_ch(IMG_W, IMG_H);
    localparam int unsigned PIX_W      = $clog2(PIX_PER_CH + 1);
    localparam int unsigned OUT_W      = $clog2(OUT_PER_CH + 1);
    localparam int unsigned TMR_W      = $clog2(DRAIN_TIMEOUT + 1);

    state_t              state;
    logic [CH_W-1:0]     ch;
    logic [CH_W-1:0]     num_ch_q;
    logic [PIX_W-1:0]    feed_cnt;
    logic [OUT_W-1:0]    out_cnt;
    logic [TMR_W-1:0]    drain_tmr;
    logic [ADDR_W-1:0]   dst_ptr;
    logic [ADDR_W-1:0]   dst_next;

    logic accept;
    logic accept_run;
    logic wr_fire;
    logic drain_full;
    logic drain_tmo;
    logic drain_exit;

    assign accept     = (state == IDLE) && start;
    assign accept_run = accept && (num_ch != CH_W'(0));
    assign wr_fire    = pool_valid_out && (state != IDLE);
    assign drain_full = (state == DRAIN) && (out_cnt == OUT_W'(OUT_PER_CH));
    assign drain_tmo  = (state == DRAIN) && !drain_full && !pool_valid_out &&
                        (drain_tmr == TMR_W'(DRAIN_TIMEOUT - 1));
    assign drain_exit = drain_full || drain_tmo;

    // The source SRAM output register is the data stage; gating with the
    // delayed read strobe keeps data and valid aligned with one cycle latency.
    assign pool_data_in = pool_valid_in ? rd_data : DATA_W'(0);

    // Source pointer steps once per read; channels are packed back to back.
    maxpool_addr_gen #(.ADDR_W(ADDR_W)) u_src_addr (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_run),
        .base      (src_base),
        .force_en  (1'b0),
        .force_val (ADDR_W'(0)),
        .inc       (rd_en),
        .addr      (rd_addr)
    );

    // Destination pointer is re-aligned at each channel end so an abandoned
    // channel does not shift the addresses of the ones after it.
    maxpool_addr_gen #(.ADDR_W(ADDR_W)) u_dst_addr (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_run),
        .base      (dst_base),
        .force_en  (drain_exit),
        .force_val (dst_next),
        .inc       (wr_fire),
        .addr      (dst_ptr)
    );

    // Sequencer FSM with registered outputs, write register and drain timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            rd_en         <= 1'b0;
            pool_valid_in <= 1'b0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            ch            <= '0;
            num_ch_q      <= '0;
            feed_cnt      <= '0;
            out_cnt       <= '0;
            drain_tmr     <= '0;
            dst_next      <= '0;
        end else begin
            done          <= 1'b0;
            pool_valid_in <= rd_en;
            wr_en         <= wr_fire;
            if (wr_fire) begin
                wr_addr <= dst_ptr;
                wr_data <= pool_data_out;
            end

            if (drain_exit) begin
                out_cnt  <= '0;
                dst_next <= dst_next + ADDR_W'(OUT_PER_CH);
            end else if (wr_fire) begin
                out_cnt <= out_cnt + OUT_W'(1);
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (num_ch != CH_W'(0)) begin
                            num_ch_q <= num_ch;
                            ch       <= '0;
                            feed_cnt <= '0;
                            out_cnt  <= '0;
                            dst_next <= dst_base + ADDR_W'(OUT_PER_CH);
                            busy     <= 1'b1;
                            rd_en    <= 1'b1;
                            state    <= FEED;
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                FEED: begin
                    if (feed_cnt == PIX_W'(PIX_PER_CH - 1)) begin
                        feed_cnt  <= '0;
                        rd_en     <= 1'b0;
                        drain_tmr <= '0;
                        state     <= DRAIN;
                    end else begin
                        feed_cnt <= feed_cnt + PIX_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_exit) begin
                        if (drain_tmo) begin
                            err <= 1'b1;
                        end
                        state <= NEXT;
                    end else if (pool_valid_out) begin
                        drain_tmr <= '0;
                    end else begin
                        drain_tmr <= drain_tmr + TMR_W'(1);
                    end
                end
                NEXT: begin
                    ch <= ch + CH_W'(1);
                    if ((ch + CH_W'(1)) == num_ch_q) begin
                        state <= FIN;
                    end else begin
                        rd_en <= 1'b1;
                        state <= FEED;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MAXPOOL_SEQ_PERF_EN
    // Busy-cycle counter: cleared per command, saturates, holds after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (accept) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != '1)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_maxpool_seq_ctrl.sv
// Bench for maxpool_seq_ctrl on a 4x4 image: source memory model, a 2x2 max
// pool core model with 2-cycle latency, and a negedge monitor of the DUT.
module tb_maxpool_seq_ctrl;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned ADDR_W        = 20;
    localparam int unsigned CH_W          = 10;
    localparam int unsigned IMG_W         = 4;
    localparam int unsigned IMG_H         = 4;
    localparam int unsigned DRAIN_TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CH_W-1:0]   num_ch = '0;
    logic [ADDR_W-1:0] src_base = '0;
    logic [ADDR_W-1:0] dst_base = '0;
    logic              busy;
    logic              done;
    logic              err;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic [DATA_W-1:0] pool_data_in;
    logic              pool_valid_in;
    logic [DATA_W-1:0] pool_data_out = '0;
    logic              pool_valid_out = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
`ifdef MAXPOOL_SEQ_PERF_EN
    logic [31:0]       perf_cycles;
`endif

    always #5 clk = ~clk;

    maxpool_seq_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CH_W(CH_W),
        .IMG_W(IMG_W), .IMG_H(IMG_H), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_ch         (num_ch),
        .src_base       (src_base),
        .dst_base       (dst_base),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .pool_data_in   (pool_data_in),
        .pool_valid_in  (pool_valid_in),
        .pool_data_out  (pool_data_out),
        .pool_valid_out (pool_valid_out),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data)
`ifdef MAXPOOL_SEQ_PERF_EN
        ,
        .perf_cycles    (perf_cycles)
`endif
    );

    // Source image, raster order; channel c adds c*0x100 (address bits [5:4]).
    logic [7:0] tbl [16] = '{8'd3, 8'd9, 8'd1, 8'd4, 8'd7, 8'd2, 8'd8, 8'd6,
                             8'd5, 8'd0, 8'd2, 8'd11, 8'd1, 8'd14, 8'd10, 8'd3};
    // Hand-computed 2x2 maxima of tbl: windows (0,1,4,5),(2,3,6,7),(8,9,12,13),(10,11,14,15).
    logic [DATA_W-1:0] exp_max [4] = '{32'd9, 32'd8, 32'd14, 32'd11};

    function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
        return DATA_W'(tbl[a[3:0]]) + (DATA_W'(a[5:4]) << 8);
    endfunction

    always @(posedge clk) rd_data <= rd_en ? mem_data(rd_addr) : '0;

    // Pool core model; drop_mode suppresses the last two windows of channel-0 data.
    logic              drop_mode = 1'b0;
    logic [DATA_W-1:0] pix [16];
    logic [3:0]        in_idx = '0;
    logic [DATA_W-1:0] win_max;
    logic              win_fire;
    logic              v1 = 1'b0;
    logic [DATA_W-1:0] d1 = '0;

    always_comb begin
        win_max = pool_data_in;
        if (pix[in_idx - 4'd1] > win_max) win_max = pix[in_idx - 4'd1];
        if (pix[in_idx - 4'd4] > win_max) win_max = pix[in_idx - 4'd4];
        if (pix[in_idx - 4'd5] > win_max) win_max = pix[in_idx - 4'd5];
        win_fire = pool_valid_in && in_idx[0] && in_idx[2] &&
                   !(drop_mode && in_idx[3] && (win_max < 32'h100));
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            in_idx <= '0;
        end else if (pool_valid_in) begin
            pix[in_idx] <= pool_data_in;
            in_idx      <= in_idx + 4'd1;
        end
    end

    // Core pipeline is not cleared by reset so in-flight results reach an idle DUT.
    always @(posedge clk) begin
        v1             <= win_fire;
        d1             <= win_max;
        pool_valid_out <= v1;
        pool_data_out  <= d1;
    end

    // Monitor
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [ADDR_W-1:0] rd_q [$];
    int                rd_cyc [$];
    logic [ADDR_W-1:0] wa_q [$];
    logic [DATA_W-1:0] wd_q [$];
    int                wr_cyc [$];
    int                done_cnt = 0;
    int                done_cyc = 0;
    int                busy_cnt = 0;
    int                st_cyc = 0;

    always @(negedge clk) begin
        if (rd_en) begin
            rd_q.push_back(rd_addr);
            rd_cyc.push_back(cyc);
        end
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            wr_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (busy) busy_cnt = busy_cnt + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clr_mon();
        rd_q.delete();
        rd_cyc.delete();
        wa_q.delete();
        wd_q.delete();
        wr_cyc.delete();
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    task automatic launch(input int n, input logic [ADDR_W-1:0] sb, input logic [ADDR_W-1:0] db);
        clr_mon();
        num_ch   = CH_W'(n);
        src_base = sb;
        dst_base = db;
        start    = 1'b1;
        st_cyc   = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (done_cnt == 0 && i < budget) begin
            tick();
            i++;
        end
        repeat (4) tick();
        check_eq("done_pulses", 64'(done_cnt), 64'(1));
        check_eq("busy_after_done", 64'(busy), 64'(0));
    endtask

    task automatic check_reads(input logic [ADDR_W-1:0] sb, input int nch);
        check_eq("rd_count", 64'(rd_q.size()), 64'(16 * nch));
        for (int i = 0; i < rd_q.size(); i++)
            check_eq($sformatf("rd_addr[%0d]", i), 64'(rd_q[i]), 64'(sb + ADDR_W'(i)));
        for (int c = 0; c < nch; c++)
            if (rd_cyc.size() >= 16 * c + 16)
                check_eq($sformatf("rd_burst[%0d]", c),
                         64'(rd_cyc[16*c+15] - rd_cyc[16*c]), 64'(15));
    endtask

    task automatic check_writes(input logic [ADDR_W-1:0] db, input int nch);
        check_eq("wr_count", 64'(wa_q.size()), 64'(4 * nch));
        for (int i = 0; i < wa_q.size(); i++) begin
            check_eq($sformatf("wr_addr[%0d]", i), 64'(wa_q[i]), 64'(db + ADDR_W'(i)));
            check_eq($sformatf("wr_data[%0d]", i), 64'(wd_q[i]),
                     64'(exp_max[i % 4] + DATA_W'((i / 4) * 256)));
        end
    endtask

    logic [ADDR_W-1:0] to_wa [6] = '{20'h200, 20'h201, 20'h204, 20'h205, 20'h206, 20'h207};
    logic [DATA_W-1:0] to_wd [6] = '{32'h9, 32'h8, 32'h109, 32'h108, 32'h10E, 32'h10B};

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) tick();
        check_eq("rst_init_ctl", 64'({busy, done, err, rd_en, pool_valid_in, wr_en, rd_addr, wr_addr}), 64'(0));
        check_eq("rst_init_data", 64'(wr_data | pool_data_in), 64'(0));
        rst = 1'b0;
        tick();

        // Single channel
        launch(1, 20'h100, 20'h200);
        wait_done(200);
        check_reads(20'h100, 1);
        if (rd_cyc.size() > 0)
            check_eq("first_rd_latency", 64'(rd_cyc[0] - st_cyc), 64'(1));
        check_writes(20'h200, 1);
        check_eq("err_single", 64'(err), 64'(0));
`ifdef MAXPOOL_SEQ_PERF_EN
        check_eq("perf_eq_busy", 64'(perf_cycles), 64'(busy_cnt));
        check_eq("perf_min", 64'(perf_cycles >= 32'd16), 64'(1));
        n = busy_cnt;
        repeat (3) tick();
        check_eq("perf_hold", 64'(perf_cycles), 64'(n));
`endif

        // Three channels
        launch(3, 20'h100, 20'h200);
        wait_done(400);
        check_reads(20'h100, 3);
        check_writes(20'h200, 3);
        for (int c = 1; c < 3; c++)
            if (rd_cyc.size() >= 16 * c + 1 && wr_cyc.size() >= 4 * c)
                check_eq($sformatf("drain_before_ch%0d", c),
                         64'(rd_cyc[16*c] > wr_cyc[4*c-1]), 64'(1));

        // Zero channels
        launch(0, 20'h100, 20'h200);
        wait_done(20);
        check_eq("zero_done_latency", 64'(done_cyc - st_cyc), 64'(2));
        check_eq("zero_rd_count", 64'(rd_q.size()), 64'(0));
        check_eq("zero_wr_count", 64'(wa_q.size()), 64'(0));
        check_eq("zero_busy_cycles", 64'(busy_cnt), 64'(0));

        // Drain timeout on channel 0
        drop_mode = 1'b1;
        launch(2, 20'h100, 20'h200);
        wait_done(400);
        drop_mode = 1'b0;
        check_eq("tmo_err", 64'(err), 64'(1));
        check_eq("tmo_wr_count", 64'(wa_q.size()), 64'(6));
        for (int i = 0; i < wa_q.size() && i < 6; i++) begin
            check_eq($sformatf("tmo_wr_addr[%0d]", i), 64'(wa_q[i]), 64'(to_wa[i]));
            check_eq($sformatf("tmo_wr_data[%0d]", i), 64'(wd_q[i]), 64'(to_wd[i]));
        end

        // Start while busy is ignored
        launch(1, 20'h100, 20'h200);
        check_eq("err_cleared", 64'(err), 64'(0));
        repeat (3) tick();
        num_ch   = CH_W'(2);
        src_base = 20'h900;
        dst_base = 20'hA00;
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_done(200);
        check_reads(20'h100, 1);
        check_writes(20'h200, 1);

        // Reset during FEED
        launch(3, 20'h100, 20'h200);
        n = 0;
        while (rd_q.size() < 7 && n < 100) begin
            tick();
            n++;
        end
        rst = 1'b1;
        #1;
        check_eq("rst_async_ctl", 64'({busy, done, err, rd_en, pool_valid_in, wr_en, rd_addr, wr_addr}), 64'(0));
        check_eq("rst_async_data", 64'(wr_data | pool_data_in), 64'(0));
        clr_mon();
        tick();
        rst = 1'b0;
        repeat (8) tick();
        check_eq("rst_no_writes", 64'(wa_q.size()), 64'(0));
        check_eq("rst_no_reads", 64'(rd_q.size()), 64'(0));
        check_eq("rst_no_done", 64'(done_cnt), 64'(0));

        // Clean run after reset
        launch(1, 20'h300, 20'h400);
        wait_done(200);
        check_reads(20'h300, 1);
        check_writes(20'h400, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
